// File: rtl/regfile_sb.sv
// Register file with per-register scoreboard busy bits, combinational reads
// with writeback bypass, and a registered count of busy registers.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_hit, iss_hit;

  assign wr_hit  = wr_en && (wr_addr != '0);
  assign iss_hit = iss_en && (iss_addr != '0) && !flush;

  // Issue is applied after writeback so a same-address collision leaves busy set.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit) busy_d[wr_addr] = 1'b0;
    if (flush) begin
      busy_d = '0;
    end else if (iss_hit) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      if (wr_hit && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
      end else if (rd_addr[k*ADDR_W +: ADDR_W] != '0) begin
        rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
      end
      rd_busy[k] = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_hit) mem_q[wr_addr] <= wr_data;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table for the scoreboard corner cases, then random traffic
// checked against an array-based model of the register file.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[16];

  // Reference model: plain arrays updated from the architectural rules.
  logic [31:0] m_reg [32];
  bit          m_busy[32];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                       input logic fl, input logic [4:0] ra0, input logic [4:0] ra1);
    rst_n    = rst;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = ia;
    flush    = fl;
    rd_addr  = {ra1, ra0};
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (wr_en && wr_addr != 0 && wr_addr == a) return wr_data;
    if (a == 0) return 32'h0;
    return m_reg[a];
  endfunction

  function automatic logic [5:0] popc();
    int n = 0;
    foreach (m_busy[i]) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      foreach (m_reg[i]) begin
        m_reg[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (flush) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else if (iss_en && iss_addr != 0) begin
        m_busy[iss_addr] = 1'b1;
      end
    end
  endtask

  initial begin
    // rst we wa wd ie ia fl ra0 ra1 | d0 d1 busy cnt (sampled before the edge)
    tbl[0]  = '{1, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 2'b00, 6'd0};
    tbl[1]  = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0};
    tbl[2]  = '{1, 1, 5'd7,  32'h1234,     0, 5'd0,  0, 5'd3,  5'd7,  32'h0, 32'h1234, 2'b00, 6'd0};
    tbl[3]  = '{1, 1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  0, 5'd0,  5'd0,  32'h0, 32'h0, 2'b00, 6'd0};
    tbl[4]  = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd0,  5'd7,  32'h0, 32'h1234, 2'b00, 6'd0};
    tbl[5]  = '{1, 0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd3,  5'd4,  32'h0, 32'h0, 2'b00, 6'd0};
    tbl[6]  = '{1, 0, 5'd0,  32'h0,        1, 5'd4,  0, 5'd3,  5'd4,  32'h0, 32'h0, 2'b01, 6'd1};
    tbl[7]  = '{1, 1, 5'd3,  32'hAA,       1, 5'd9,  0, 5'd3,  5'd9,  32'hAA, 32'h0, 2'b01, 6'd2};
    tbl[8]  = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd3,  5'd9,  32'hAA, 32'h0, 2'b10, 6'd2};
    tbl[9]  = '{1, 1, 5'd12, 32'h55,       1, 5'd12, 0, 5'd12, 5'd4,  32'h55, 32'h0, 2'b10, 6'd2};
    tbl[10] = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd12, 5'd4,  32'h55, 32'h0, 2'b11, 6'd3};
    tbl[11] = '{1, 0, 5'd0,  32'h0,        1, 5'd20, 1, 5'd20, 5'd12, 32'h0, 32'h55, 2'b10, 6'd3};
    tbl[12] = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd20, 5'd12, 32'h0, 32'h55, 2'b00, 6'd0};
    tbl[13] = '{0, 1, 5'd5,  32'h1,        1, 5'd6,  1, 5'd5,  5'd7,  32'h1, 32'h1234, 2'b00, 6'd0};
    tbl[14] = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd5,  5'd7,  32'h0, 32'h0, 2'b00, 6'd0};
    tbl[15] = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd6,  5'd12, 32'h0, 32'h0, 2'b00, 6'd0};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 5'd9, 5'd31);
    #1;
    check("reset_rd0", rd_data[31:0], 32'h0);
    check("reset_rd1", rd_data[63:32], 32'h0);
    check("reset_busy", {30'h0, rd_busy}, 32'h0);
    check("reset_cnt", {26'h0, busy_cnt}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ia, tbl[i].fl,
            tbl[i].ra0, tbl[i].ra1);
      #1;
      check($sformatf("vec%0d_rd0", i), rd_data[31:0], tbl[i].d0);
      check($sformatf("vec%0d_rd1", i), rd_data[63:32], tbl[i].d1);
      check($sformatf("vec%0d_busy", i), {30'h0, rd_busy}, {30'h0, tbl[i].b});
      check($sformatf("vec%0d_cnt", i), {26'h0, busy_cnt}, {26'h0, tbl[i].cnt});
      @(posedge clk);
      @(negedge clk);
    end

    // Resynchronise the model with an explicit reset before random traffic.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_edge();
    @(negedge clk);

    for (int c = 0; c < 800; c++) begin
      logic [4:0] wa, ia, ra0, ra1;
      wa  = 5'($urandom_range(0, 31));
      ia  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 7) == 0) ? ra0 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)), wa, $urandom,
            ($urandom_range(0, 3) != 0), ia, ($urandom_range(0, 19) == 0), ra0, ra1);
      #1;
      check($sformatf("rnd%0d_rd0", c), rd_data[31:0], exp_rd(ra0));
      check($sformatf("rnd%0d_rd1", c), rd_data[63:32], exp_rd(ra1));
      check($sformatf("rnd%0d_busy", c), {30'h0, rd_busy},
            {30'h0, (ra1 == 0) ? 1'b0 : 1'(m_busy[ra1]), (ra0 == 0) ? 1'b0 : 1'(m_busy[ra0])});
      check($sformatf("rnd%0d_cnt", c), {26'h0, busy_cnt}, {26'h0, popc()});
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
